tensor_sequencer: RTL and testbench
===================================

TENSOR_SEQUENCER -- requirements
Module: tensor_sequencer

Interface
REQ-001 Parameter: ELEMS, default 9, number of 16-bit elements per 3x3 tensor.
REQ-002 Parameter: AW, default 9, data-memory address width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle command strobe.
REQ-006 Port: cmd  input  2  operation select: 00 LOAD_A, 01 LOAD_B, 10 STORE_REZ, 11 FULL.
REQ-007 Port: base_a, base_b, base_r  input  AW each  element-0 address of A, B, and result tensors.
REQ-008 Port: dm_gnt  input  1  data-memory grant for the current request.
REQ-009 Port: dm_addr  output  AW  data-memory address.
REQ-010 Port: dm_rd, dm_wr  output  1 each  data-memory read and write request.
REQ-011 Port: elem_idx  output  4  current element index, 0..ELEMS-1.
REQ-012 Port: a_we, b_we  output  1 each  write strobe for A or B register element elem_idx.
REQ-013 Port: mxu_capture  output  1  latch the MXU output into the tensor accumulator.
REQ-014 Port: busy, done, err  output  1 each  status flags.

Function
REQ-015 States SHALL be IDLE, LD_A, LD_B, COMPUTE, ST_R and FIN, with a binary encoding.
REQ-016 In IDLE, start=1 SHALL latch cmd, base_a, base_b and base_r, clear elem_idx, and enter the first state:
- cmd 00 -> LD_A
- cmd 01 -> LD_B
- cmd 10 -> ST_R
- cmd 11 -> LD_A
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 In LD_A and LD_B, dm_rd SHALL be 1 and dm_addr SHALL be the latched base + elem_idx, truncated mod 2^AW (address 511+1 wraps to 0).
REQ-019 In ST_R, dm_wr SHALL be 1 and dm_addr SHALL be base_r + elem_idx, with the same wrap rule.
REQ-020 An element SHALL complete only in a cycle where a request is active and dm_gnt=1.
- LD_A: a_we=1 combinationally in that cycle.
- LD_B: b_we=1 combinationally in that cycle.
- elem_idx increments at the next edge.
REQ-021 With dm_gnt=0, dm_addr, elem_idx and the request lines SHALL hold (wait states), for an unlimited number of cycles.
REQ-022 When element ELEMS-1 completes, elem_idx SHALL return to 0 and the next state SHALL be:
- LD_A, cmd 11 -> LD_B
- LD_A, cmd 00 -> FIN
- LD_B, cmd 11 -> COMPUTE
- LD_B, cmd 01 -> FIN
- ST_R -> FIN
REQ-023 COMPUTE SHALL last exactly one cycle with mxu_capture=1 and no DM request, then enter ST_R.
REQ-024 FIN SHALL last one cycle with done=1, then enter IDLE; start in FIN SHALL be ignored.
REQ-025 start=1 while busy=1 SHALL be ignored: the current sequence is unaffected and err=1 for that one cycle.
REQ-026 a_we, b_we, mxu_capture, dm_rd and dm_wr SHALL never be asserted simultaneously; dm_rd and dm_wr SHALL be 0 in IDLE, COMPUTE and FIN.
REQ-027 Minimum latency from start to done SHALL be:
- single-tensor cmd: ELEMS+2 cycles
- FULL: 3*ELEMS+3 cycles
- each dm_gnt=0 cycle adds exactly one cycle.

Reset
REQ-028 reset=0 SHALL immediately and asynchronously force the state to IDLE, clear all latched registers, and drive every output to 0, including mid-sequence.
REQ-029 After reset is released, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-030 Single load: cmd=00, base_a=0x010, dm_gnt tied 1 -> dm_addr 0x010..0x018 over 9 cycles, a_we high 9 cycles, done at cycle 11 after start, busy low after.
REQ-031 Full sequence: cmd=11, bases 0x000/0x020/0x040, dm_gnt=1 -> LD_A 9, LD_B 9, one mxu_capture, 9 dm_wr at 0x040..0x048; done 30 cycles after start.
REQ-032 Wait states: cmd=01, dm_gnt=0 on elements 3 and 8 for 2 cycles each -> dm_addr and elem_idx held; done 4 cycles later than the REQ-030 case.
REQ-033 Wrap: cmd=10, base_r=0x1FC -> addresses 0x1FC..0x1FF then 0x000..0x004.
REQ-034 Collision: start pulsed during LD_B of a FULL sequence -> err one cycle, sequence completes unchanged.
REQ-035 Reset mid-operation: reset=0 during ST_R at elem_idx=5 -> all outputs 0 at once without a clock edge; after release, new cmd=00 runs from elem_idx 0.

Source files
------------

// File: rtl/tensor_sequencer.sv
// Tensor load/compute/store sequencer: walks A/B loads and result stores through
// a granted data-memory port and pulses the MXU capture between loads and store.
module tensor_sequencer #(
  parameter int unsigned ELEMS = 9,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_r,
  input  logic          dm_gnt,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [3:0]    elem_idx,
  output logic          a_we,
  output logic          b_we,
  output logic          mxu_capture,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned IW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(ELEMS - 1);

  localparam logic [1:0] CMD_LOAD_A = 2'b00;
  localparam logic [1:0] CMD_LOAD_B = 2'b01;
  localparam logic [1:0] CMD_STORE  = 2'b10;
  localparam logic [1:0] CMD_FULL   = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_A    = 3'd1,
    LD_B    = 3'd2,
    COMPUTE = 3'd3,
    ST_R    = 3'd4,
    FIN     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [AW-1:0] base_r_q, base_r_d;
  logic [IW-1:0] idx_q, idx_d;

  // State and latched command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cmd_q    <= 2'b00;
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_r_q <= base_r_d;
      idx_q    <= idx_d;
    end
  end

  assign elem_idx = idx_q;

  // Next-state and decoded outputs; memory strobes stay asserted through wait states
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    base_r_d    = base_r_q;
    idx_d       = idx_q;
    dm_addr     = '0;
    dm_rd       = 1'b0;
    dm_wr       = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    mxu_capture = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d    = cmd;
          base_a_d = base_a;
          base_b_d = base_b;
          base_r_d = base_r;
          idx_d    = '0;
          case (cmd)
            CMD_LOAD_B: state_d = LD_B;
            CMD_STORE:  state_d = ST_R;
            default:    state_d = LD_A;
          endcase
        end
      end
      LD_A: begin
        dm_rd   = 1'b1;
        dm_addr = base_a_q + AW'(idx_q);
        if (dm_gnt) begin
          a_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (cmd_q == CMD_FULL) ? LD_B : FIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LD_B: begin
        dm_rd   = 1'b1;
        dm_addr = base_b_q + AW'(idx_q);
        if (dm_gnt) begin
          b_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (cmd_q == CMD_FULL) ? COMPUTE : FIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      COMPUTE: begin
        mxu_capture = 1'b1;
        state_d     = ST_R;
      end
      ST_R: begin
        dm_wr   = 1'b1;
        dm_addr = base_r_q + AW'(idx_q);
        if (dm_gnt) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = start && (state_q != IDLE);

  // CMD_LOAD_A only selects the default branch of the start decode
  logic unused_cmd_ok;
  assign unused_cmd_ok = (CMD_LOAD_A == 2'b00);

endmodule

// File: tb/tb_tensor_sequencer.sv
// Self-checking bench for tensor_sequencer: per-cycle comparison against a
// queue-based model of the element transfers a command should produce.
module tb_tensor_sequencer;

  localparam int AW    = 9;
  localparam int ELEMS = 9;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    cmd;
  logic [AW-1:0] base_a, base_b, base_r;
  logic          dm_gnt;
  logic [AW-1:0] dm_addr;
  logic          dm_rd, dm_wr;
  logic [3:0]    elem_idx;
  logic          a_we, b_we, mxu_capture, busy, done, err;

  tensor_sequencer #(.ELEMS(ELEMS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .base_a(base_a), .base_b(base_b), .base_r(base_r), .dm_gnt(dm_gnt),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .elem_idx(elem_idx),
    .a_we(a_we), .b_we(b_we), .mxu_capture(mxu_capture),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy,done,err,dm_rd,dm_wr,a_we,b_we,mxu_capture,elem_idx,dm_addr}
  logic [20:0] obs;
  assign obs = {busy, done, err, dm_rd, dm_wr, a_we, b_we, mxu_capture, elem_idx, dm_addr};

  int errors = 0;
  int checks = 0;

  // Model: ordered list of transfers (kind 0=A read, 1=B read, 2=compute, 3=R write)
  int        m_kind[$];
  int        m_addr[$];
  int        m_idx[$];
  int        n_awe, n_bwe, n_cap, n_wr, n_err, stalls;
  logic [8:0] wr_addrs[$];

  task automatic add_phase(input int kind, input int base);
    for (int i = 0; i < ELEMS; i++) begin
      m_kind.push_back(kind);
      m_addr.push_back((base + i) % (1 << AW));
      m_idx.push_back(i);
    end
  endtask

  // mode 0: grant always, 1: random grant, 2: two-cycle stall on elements 3 and 8
  task automatic run_seq(input logic [1:0] c, input int ba, input int bb, input int br,
                         input int mode, input bit collide, output int lat);
    int p, waited, kind;
    bit g, fin_seen, st;
    logic [20:0] exp_v;
    m_kind.delete(); m_addr.delete(); m_idx.delete(); wr_addrs.delete();
    n_awe = 0; n_bwe = 0; n_cap = 0; n_wr = 0; n_err = 0; stalls = 0;
    case (c)
      2'b00: add_phase(0, ba);
      2'b01: add_phase(1, bb);
      2'b10: add_phase(3, br);
      default: begin
        add_phase(0, ba);
        add_phase(1, bb);
        m_kind.push_back(2); m_addr.push_back(0); m_idx.push_back(0);
        add_phase(3, br);
      end
    endcase

    @(negedge clk);
    start = 1'b1; cmd = c; base_a = 9'(ba); base_b = 9'(bb); base_r = 9'(br); dm_gnt = 1'b1;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL start_idle: got %h expected %h", obs, 21'h0);
    end
    lat = 1;
    p = 0; waited = 0; fin_seen = 0;
    for (int cyc = 0; cyc < 400 && !fin_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0; st = 1'b0;
      lat++;
      if (p < m_kind.size()) begin
        kind = m_kind[p];
        case (mode)
          1: g = ($urandom_range(0, 3) != 0);
          2: g = !((m_idx[p] == 3 || m_idx[p] == 8) && waited < 2);
          default: g = 1'b1;
        endcase
        if (collide && kind == 1 && m_idx[p] == 4 && waited == 0) st = 1'b1;
      end else begin
        kind = -1;
        g = 1'b1;
        if (collide) st = 1'b1;
      end
      dm_gnt = g;
      if (st) begin
        start = 1'b1; cmd = 2'($urandom);
        base_a = 9'($urandom); base_b = 9'($urandom); base_r = 9'($urandom);
      end
      #1;
      if (kind >= 0) begin
        exp_v = {1'b1, 1'b0, st, 1'(kind == 0 || kind == 1), 1'(kind == 3),
                 1'(kind == 0 && g), 1'(kind == 1 && g), 1'(kind == 2),
                 4'(m_idx[p]), 9'(m_addr[p])};
      end else begin
        exp_v = {1'b1, 1'b1, st, 18'h0};
      end
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL cycle cmd=%0d step=%0d: got %h expected %h", c, p, obs, exp_v);
      end
      n_awe += int'(a_we); n_bwe += int'(b_we); n_cap += int'(mxu_capture);
      n_err += int'(err);
      if (dm_wr && dm_gnt) begin
        n_wr++;
        wr_addrs.push_back(dm_addr);
      end
      if (kind < 0) fin_seen = 1'b1;
      else if (kind == 2 || g) begin p++; waited = 0; end
      else begin waited++; stalls++; end
    end
    checks++;
    if (!fin_seen) begin
      errors++;
      $display("FAIL timeout cmd=%0d: done never observed, expected by step %0d", c, m_kind.size());
    end
    @(negedge clk);
    start = 1'b0; dm_gnt = 1'b0;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL back_to_idle: got %h expected %h", obs, 21'h0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; cmd = 2'b11; dm_gnt = 1'b1;
    base_a = 9'h1AB; base_b = 9'h0CD; base_r = 9'h1EF;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_load();
    int lat;
    run_seq(2'b00, 'h010, 'h0, 'h0, 0, 1'b0, lat);
    checks++;
    if (lat !== ELEMS + 2) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", lat, ELEMS + 2);
    end
    checks++;
    if (n_awe !== 9 || n_bwe !== 0) begin
      errors++; $display("FAIL single_we: got a=%0d b=%0d expected a=9 b=0", n_awe, n_bwe);
    end
  endtask

  task automatic test_full();
    int lat;
    run_seq(2'b11, 'h000, 'h020, 'h040, 0, 1'b0, lat);
    checks++;
    if (lat !== 3 * ELEMS + 3) begin
      errors++; $display("FAIL full_latency: got %0d expected %0d", lat, 3 * ELEMS + 3);
    end
    checks++;
    if (n_awe !== 9 || n_bwe !== 9 || n_cap !== 1 || n_wr !== 9) begin
      errors++;
      $display("FAIL full_counts: got a=%0d b=%0d cap=%0d wr=%0d expected 9 9 1 9",
               n_awe, n_bwe, n_cap, n_wr);
    end
    checks++;
    if (wr_addrs.size() != 9 || wr_addrs[0] !== 9'h040 || wr_addrs[8] !== 9'h048) begin
      errors++; $display("FAIL full_wr_range: got %0d writes expected 0x040..0x048", wr_addrs.size());
    end
  endtask

  task automatic test_wait_states();
    int lat;
    run_seq(2'b01, 'h0, 'h0A0, 'h0, 2, 1'b0, lat);
    checks++;
    if (lat !== ELEMS + 2 + 4 || stalls !== 4) begin
      errors++;
      $display("FAIL wait_latency: got %0d (stalls %0d) expected %0d (stalls 4)", lat, stalls, ELEMS + 6);
    end
    checks++;
    if (n_bwe !== 9) begin
      errors++; $display("FAIL wait_bwe: got %0d expected 9", n_bwe);
    end
  endtask

  task automatic test_wrap();
    int lat;
    run_seq(2'b10, 'h0, 'h0, 'h1FC, 0, 1'b0, lat);
    checks++;
    if (wr_addrs.size() != 9 || wr_addrs[0] !== 9'h1FC || wr_addrs[3] !== 9'h1FF ||
        wr_addrs[4] !== 9'h000 || wr_addrs[8] !== 9'h004) begin
      errors++; $display("FAIL wrap_addrs: got %0d writes, expected 0x1FC..0x1FF,0x000..0x004", wr_addrs.size());
    end
    checks++;
    if (lat !== ELEMS + 2) begin
      errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, ELEMS + 2);
    end
  endtask

  task automatic test_collision();
    int lat;
    run_seq(2'b11, 'h000, 'h020, 'h040, 0, 1'b1, lat);
    checks++;
    if (lat !== 3 * ELEMS + 3 || n_err !== 2) begin
      errors++; $display("FAIL collision: got lat=%0d err=%0d expected lat=%0d err=2", lat, n_err, 3 * ELEMS + 3);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start = 1'b1; cmd = 2'b10; base_r = 9'h100; dm_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (elem_idx !== 4'd5 || dm_wr !== 1'b1 || dm_addr !== 9'h105) begin
      errors++; $display("FAIL mid_pre_reset: got idx=%0d wr=%b addr=%h expected 5 1 105", elem_idx, dm_wr, dm_addr);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL mid_async_reset: got %h expected %h", obs, 21'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_seq(2'b00, 'h033, 'h0, 'h0, 0, 1'b0, lat);
    checks++;
    if (lat !== ELEMS + 2) begin
      errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, ELEMS + 2);
    end
  endtask

  task automatic test_random();
    int lat, base_lat;
    logic [1:0] c;
    for (int n = 0; n < 12; n++) begin
      c = 2'($urandom);
      run_seq(c, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 511)), 1, 1'b0, lat);
      base_lat = (c == 2'b11) ? 3 * ELEMS + 3 : ELEMS + 2;
      checks++;
      if (lat !== base_lat + stalls) begin
        errors++; $display("FAIL random_latency cmd=%0d: got %0d expected %0d", c, lat, base_lat + stalls);
      end
    end
  endtask

  initial begin
    start = 1'b0; cmd = 2'b00; dm_gnt = 1'b0;
    base_a = '0; base_b = '0; base_r = '0;
    test_reset();
    test_single_load();
    test_full();
    test_wait_states();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
